// File: rtl/hist_pkg.sv
// Shared constants and FSM encoding for the histogram image path.
// Holds the default frame geometry (W x H) and the derived pixel count and
// address width, plus the reader state type. ram_out_reader and ram_out both
// pull their defaults from here so the frame geometry is defined in one place.
package hist_pkg;

    localparam int W               = 64;
    localparam int H               = 64;
    localparam int TOTAL_PIXEL     = W * H;
    localparam int TOTAL_PIXEL_BIT = $clog2(W * H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for start
        ST_READ  = 2'd1,  // addresses still to issue
        ST_DRAIN = 2'd2   // all addresses issued, pixels still buffered or in flight
    } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer with valid/ready handshakes on both sides.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   in_data_i/in_valid_i  write side; in_ready_o high when an entry is free
//                         (or one is being freed by a transfer this cycle)
//   out_data_o/out_valid_o/out_ready_i  read side, AXI-stream style
//   count_o               number of occupied entries (0..2)
// The head entry drives the output directly from a register, so the output
// is stable while stalled.
module skid_buf2 #(
    parameter int DW = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [1:0]    count_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = count_q;
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = (count_q != 2'd2) || pop;
    assign push        = in_valid_i && in_ready_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data_i;
                else                 tail_d = in_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Head only moves when a second entry is behind it.
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_out_reader.sv
// Streams one frame out of ram_out as an AXI-stream-like pixel sequence.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request to stream a frame (ignored while busy)
//   rd_addr         ram_out read address (ascending 0..TOTAL_PIXEL-1)
//   rd_data         ram_out read data, valid one cycle after rd_addr
//   out_data        streamed pixel
//   out_valid       out_data holds a valid pixel
//   out_ready       downstream accept
//   out_last        marks the pixel from address TOTAL_PIXEL-1
//   busy            frame in progress
//   done            one-cycle pulse after the out_last transfer
// Reads are issued only when the 2-entry buffer can hold the result, so a
// stalled consumer never loses the pixel already in flight from the RAM.
module ram_out_reader #(
    parameter int W               = hist_pkg::W,
    parameter int H               = hist_pkg::H,
    parameter int TOTAL_PIXEL     = W * H,
    parameter int TOTAL_PIXEL_BIT = $clog2(W * H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
    input  logic [7:0]                 rd_data,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    import hist_pkg::*;

    localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

    rd_state_t                  state_q, state_d;
    logic [TOTAL_PIXEL_BIT-1:0] addr_q, addr_d;
    logic                       inflight_q, inflight_d;
    logic                       inflight_last_q, inflight_last_d;
    logic                       done_q, done_d;

    logic       sb_in_ready;
    logic [8:0] sb_out_data;
    logic       sb_out_valid;
    logic [1:0] sb_count;
    logic       xfer;
    logic [2:0] occupancy;
    logic       can_issue;

    skid_buf2 #(.DW(9)) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   ({inflight_last_q, rd_data}),
        .in_valid_i  (inflight_q),
        .in_ready_o  (sb_in_ready),
        .out_data_o  (sb_out_data),
        .out_valid_o (sb_out_valid),
        .out_ready_i (out_ready),
        .count_o     (sb_count)
    );

    assign xfer      = sb_out_valid && out_ready;
    // Buffered + in-flight pixels after this cycle's transfer; xfer implies
    // sb_count >= 1, so the subtraction never underflows.
    assign occupancy = {1'b0, sb_count} + {2'b00, inflight_q} - {2'b00, xfer};
    assign can_issue = sb_in_ready && (occupancy < 3'd2);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (can_issue) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (addr_q == LAST_ADDR);
                    // Hold at the last address rather than wrapping to 0.
                    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (xfer && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign rd_addr   = addr_q;
    assign out_data  = sb_out_data[7:0];
    assign out_valid = sb_out_valid;
    assign out_last  = sb_out_data[8] && sb_out_valid;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ram_out_reader.sv
module tb_ram_out_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 64x64 instance
    logic        a_rst = 1'b0, a_start = 1'b0, a_out_ready = 1'b0;
    logic [11:0] a_rd_addr;
    logic [7:0]  a_rd_data, a_out_data;
    logic        a_out_valid, a_out_last, a_busy, a_done;
    logic [7:0]  a_mem [0:4095];

    ram_out_reader #(.W(64), .H(64)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );
    always @(posedge clk) a_rd_data <= a_mem[a_rd_addr];

    // 3x5 instance
    logic       b_rst = 1'b0, b_start = 1'b0, b_out_ready = 1'b0;
    logic [3:0] b_rd_addr;
    logic [7:0] b_rd_data, b_out_data;
    logic       b_out_valid, b_out_last, b_busy, b_done;
    logic [7:0] b_mem [0:14];

    ram_out_reader #(.W(3), .H(5)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );
    always @(posedge clk) b_rd_data <= b_mem[b_rd_addr];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } pix_t;
    pix_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready=1, 1: random ready, 2: 20-cycle stall at first valid,
    // 3: ready=1 with a second start at pixel 100.
    task automatic a_frame(input int mode, input int abort_at, input bit prestarted, input bit chain);
        int   n, k, first_k, last_k, stall_left;
        bit   seen_valid, prev_stall, prev_lastx, finished, restart_done;
        logic [7:0] prev_d;
        logic prev_l;
        pix_t e;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) begin
            e.d = 8'(i);
            e.l = (i == 4095);
            exp_q.push_back(e);
        end
        if (!prestarted) begin
            @(negedge clk);
            a_start = 1'b1;
        end
        n = 0; k = 0; first_k = -1; last_k = -1; stall_left = 20;
        seen_valid = 0; prev_stall = 0; prev_lastx = 0; finished = 0; restart_done = 0;
        prev_d = '0; prev_l = 1'b0;
        while (!finished && k < 20000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                a_start = 1'b0;
                check("busy_after_start", 32'(a_busy), 1);
                check("addr_after_start", 32'(a_rd_addr), 0);
                check("valid_k1", 32'(a_out_valid), 0);
            end
            if (k == 2) check("valid_k2", 32'(a_out_valid), 0);
            if (k == 3) check("first_valid_k3", 32'(a_out_valid), 1);
            if (abort_at > 0 && n == abort_at) begin
                a_rst = 1'b1;
                #1;
                check("abort_addr", 32'(a_rd_addr), 0);
                check("abort_data", 32'(a_out_data), 0);
                check("abort_valid", 32'(a_out_valid), 0);
                check("abort_last", 32'(a_out_last), 0);
                check("abort_busy", 32'(a_busy), 0);
                check("abort_done", 32'(a_done), 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(a_done), 0);
                end
                a_rst = 1'b0;
                @(negedge clk);
                check("abort_idle_busy", 32'(a_busy), 0);
                check("abort_idle_done", 32'(a_done), 0);
                return;
            end
            if (mode == 3 && k > 1) begin
                if (n == 100 && !restart_done) begin
                    a_start = 1'b1;
                    restart_done = 1;
                end else begin
                    a_start = 1'b0;
                end
            end
            check("done_pulse", 32'(a_done), 32'(prev_lastx));
            if (a_done) begin
                check("busy_at_done", 32'(a_busy), 0);
                finished = 1;
                if (chain) a_start = 1'b1;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(a_out_valid), 1);
                    check("stall_data", 32'(a_out_data), 32'(prev_d));
                    check("stall_last", 32'(a_out_last), 32'(prev_l));
                end
                if (a_out_valid) seen_valid = 1;
                case (mode)
                    1: a_out_ready = 1'($urandom_range(0, 1));
                    2: begin
                        if (seen_valid && stall_left > 0) begin
                            a_out_ready = 1'b0;
                            stall_left--;
                        end else begin
                            a_out_ready = 1'b1;
                        end
                    end
                    default: a_out_ready = 1'b1;
                endcase
                if (mode == 2 && seen_valid && !a_out_ready)
                    check("addr_lead_le2", 32'(32'(a_rd_addr) <= n + 2), 1);
                prev_lastx = 0;
                if (a_out_valid && a_out_ready) begin
                    check("queue_nonempty", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("data", 32'(a_out_data), 32'(e.d));
                        check("last", 32'(a_out_last), 32'(e.l));
                        prev_lastx = e.l;
                    end
                    if (first_k < 0) first_k = k;
                    last_k = k;
                    n++;
                end
                prev_stall = a_out_valid && !a_out_ready;
                prev_d = a_out_data;
                prev_l = a_out_last;
            end
        end
        check("frame_finished", 32'(finished), 1);
        check("xfer_count", n, 4096);
        check("queue_empty", exp_q.size(), 0);
        check("addr_hold", 32'(a_rd_addr), 4095);
        if (mode == 0 || mode == 3) check("no_bubbles", last_k - first_k, 4095);
    endtask

    initial begin
        int   m, bk;
        bit   b_fin, b_prevlast;
        for (int i = 0; i < 4096; i++) a_mem[i] = 8'(i % 256);
        for (int i = 0; i < 15; i++)   b_mem[i] = 8'(i % 256);

        // Reset state
        #2;
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        check("rst_addr", 32'(a_rd_addr), 0);
        check("rst_data", 32'(a_out_data), 0);
        check("rst_valid", 32'(a_out_valid), 0);
        check("rst_last", 32'(a_out_last), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("b_rst_addr", 32'(b_rd_addr), 0);
        check("b_rst_valid", 32'(b_out_valid), 0);
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_wait_busy", 32'(a_busy), 0);

        a_frame(0, 0, 1'b0, 1'b1);   // full-rate frame, next start on done
        a_frame(1, 0, 1'b1, 1'b0);   // random backpressure
        a_frame(2, 0, 1'b0, 1'b0);   // long stall after first pixel
        a_frame(3, 0, 1'b0, 1'b0);   // start while busy is ignored
        a_frame(0, 2000, 1'b0, 1'b0);// reset mid-frame
        a_frame(0, 0, 1'b0, 1'b0);   // clean frame after abort

        // 3x5 frame
        @(negedge clk);
        b_start = 1'b1;
        b_out_ready = 1'b1;
        m = 0; bk = 0; b_fin = 0; b_prevlast = 0;
        while (!b_fin && bk < 200) begin
            @(negedge clk);
            bk++;
            b_start = 1'b0;
            check("b_done_pulse", 32'(b_done), 32'(b_prevlast));
            b_prevlast = 0;
            if (b_done) begin
                b_fin = 1;
            end else if (b_out_valid && b_out_ready) begin
                check("b_data", 32'(b_out_data), 32'(m));
                check("b_last", 32'(b_out_last), 32'(m == 14));
                b_prevlast = (m == 14);
                m++;
            end
        end
        check("b_finished", 32'(b_fin), 1);
        check("b_xfer_count", m, 15);
        check("b_addr_hold", 32'(b_rd_addr), 14);
        repeat (4) @(negedge clk);
        check("b_addr_hold_later", 32'(b_rd_addr), 14);
        check("b_idle_busy", 32'(b_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_out_reader.md
RAM_OUT_READER -- requirements
Module: ram_out_reader

Interface
REQ-001 Parameter W, default 64, image width in pixels.
REQ-002 Parameter H, default 64, image height in pixels.
REQ-003 Parameter TOTAL_PIXEL, default W*H, pixels per frame.
REQ-004 Parameter TOTAL_PIXEL_BIT, default $clog2(W*H), address width.
REQ-005 clk  input  1  single clock; every register updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to stream one frame.
REQ-008 rd_addr  output  TOTAL_PIXEL_BIT  read address to ram_out.
REQ-009 rd_data  input  8  ram_out read data, valid one cycle after rd_addr.
REQ-010 out_data  output  8  streamed pixel.
REQ-011 out_valid  output  1  out_data holds a valid pixel.
REQ-012 out_ready  input  1  downstream accepts; a transfer happens when out_valid && out_ready.
REQ-013 out_last  output  1  marks pixel TOTAL_PIXEL-1.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 FSM states: IDLE, READ (addresses still to issue), DRAIN (all addresses issued, pixels still buffered or in flight).
REQ-017 IDLE -> READ when start=1 at a rising edge; busy=1 from the next cycle.
REQ-018 start while busy=1 is ignored, with no effect on address, data or state.
REQ-019 Addresses are issued in ascending order 0..TOTAL_PIXEL-1, exactly once each, with no skips or repeats.
REQ-020 A read is issued only when the 2-entry output buffer has room for it: buffered pixels + pixels in flight < 2, or a transfer completes in the same cycle.
REQ-021 rd_data is captured one cycle after its address is issued; that capture is the in-flight slot.
REQ-022 With out_ready held at 1, first out_valid=1 occurs 2 cycles after the start edge, and then one pixel per cycle with no bubbles.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and out_valid stay stable (AXI-stream rule).
REQ-024 out_valid never drops without a transfer.
REQ-025 Deasserting out_ready loses no pixels and duplicates none; the skid entry absorbs the in-flight read.
REQ-026 READ -> DRAIN once address TOTAL_PIXEL-1 has been issued.
REQ-027 rd_addr stays at TOTAL_PIXEL-1 in DRAIN and IDLE, and does not wrap to 0.
REQ-028 out_last=1 only together with the pixel read from address TOTAL_PIXEL-1.
REQ-029 DRAIN -> IDLE on the out_last transfer.
REQ-030 done=1 for exactly the cycle after the out_last transfer; busy=0 in that same cycle.
REQ-031 A start in the same cycle as done=1 is accepted, and the new frame begins from address 0.
REQ-032 The address counter is TOTAL_PIXEL_BIT wide.
REQ-033 The pixel count compare uses TOTAL_PIXEL-1, so W*H that is not a power of two works.

Reset
REQ-034 rst=1 asynchronously forces: state IDLE, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, buffer empty, in-flight flag cleared.
REQ-035 Reset mid-frame aborts the frame: no done pulse, and the next start streams from address 0.
REQ-036 On release of rst, the block waits in IDLE for start.

Structure
REQ-037 Shared package hist_pkg holds W, H, TOTAL_PIXEL, TOTAL_PIXEL_BIT and the FSM state encodings; ram_out uses the same package.
REQ-038 Sub-module skid_buf2 is the 2-entry output buffer with valid/ready on both sides and a count output used by the issue logic.
REQ-039 ram_out_reader contains only the FSM, the address counter, the in-flight tracking and the last/done logic.

Verification
REQ-040 Preload ram_out with mem[i]=i%256; pulse start; hold out_ready=1 -> 4096 transfers in 4096 consecutive cycles, data 00,01..ff repeating, out_last on transfer 4096, done 1 cycle later.
REQ-041 Random out_ready at 50% -> the same 4096-value sequence, with no loss or duplicates; out_data stays stable during every stall.
REQ-042 out_ready=0 for 20 cycles after the first out_valid -> rd_addr advances at most 2 past the last consumed pixel; the stream resumes with the correct next value.
REQ-043 Pulse start again at pixel 100 -> ignored; frame completes normally with 4096 transfers.
REQ-044 Assert rst at pixel 2000 -> all outputs 0 asynchronously, no done pulse; a new start streams 00 from address 0.
REQ-045 W=3, H=5 (TOTAL_PIXEL=15) -> 15 transfers, out_last on data 0e, rd_addr holds at 14.
